if_fetch_stage: RTL

Instruction-fetch stage of the RISC-V core: owns the PC register, issues word reads to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents `instr[31:0]` with a valid/ready handshake to decode, where the `instr[31:7]` slice feeds the immediate extender. Taken branches and jumps, whose targets come from `immext`, redirect fetch and flush all in-flight and buffered instructions.

---
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch: PC register, credit-limited imem requests,
//            in-order response buffer and decode handshake with redirect flush.
//            Define IF_RSP_BYPASS_EN to present an undropped response arriving
//            at an empty buffer to decode in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    localparam int unsigned   C_CW      = $clog2(DEPTH + 1);
    localparam int unsigned   C_PW      = $clog2(DEPTH);
    localparam logic [C_CW:0] C_DEPTH   = (C_CW + 1)'(DEPTH);
    localparam logic [31:0]   C_PC_MASK = 32'hFFFF_FFFC;

    logic [31:0]     pc_q, pc_d;
    logic [C_CW-1:0] out_q, out_d, drop_q, drop_d, count_q, count_d;
    logic [C_PW-1:0] rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;
    logic [C_PW-1:0] head_q, head_d, tail_q, tail_d;

    logic [31:0] rq_pc_mem    [DEPTH];
    logic [31:0] buf_data_mem [DEPTH];
    logic [31:0] buf_pc_mem   [DEPTH];

    logic        req_fire, rsp_keep, bypass, push, pop, buf_pop, head_avail;
    logic [31:0] rsp_pc;

    function automatic logic [C_PW-1:0] ptr_inc(input logic [C_PW-1:0] p);
        if (p == C_PW'(DEPTH - 1)) return '0;
        return p + C_PW'(1);
    endfunction

    assign rsp_pc    = rq_pc_mem[rq_head_q];
    assign imem_addr = pc_q;
    assign rsp_keep  = !reset && !redirect && imem_rsp_valid && (drop_q == '0);

`ifdef IF_RSP_BYPASS_EN
    assign bypass = rsp_keep && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_avail  = (count_q != '0) || bypass;
    assign instr_valid = !reset && !redirect && head_avail;
    assign pop         = instr_valid && instr_ready;
    assign buf_pop     = pop && (count_q != '0);
    assign push        = rsp_keep && !(bypass && instr_ready);

    // A head leaving the buffer this cycle frees its slot, letting zero-wait memory stream
    assign imem_req_valid = !reset && !redirect &&
                            (({1'b0, out_q} + {1'b0, count_q} - (C_CW + 1)'(buf_pop)) < C_DEPTH);
    assign req_fire = imem_req_valid && imem_req_ready;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (bypass) begin
            instr    = imem_rsp_data;
            instr_pc = rsp_pc;
        end else if (count_q != '0) begin
            instr    = buf_data_mem[head_q];
            instr_pc = buf_pc_mem[head_q];
        end
        instr_pcplus4 = head_avail ? (instr_pc + 32'd4) : '0;
    end

    always_comb begin
        pc_d      = pc_q;
        drop_d    = drop_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rq_head_d = rq_head_q;
        rq_tail_d = rq_tail_q;
        out_d     = out_q + C_CW'(req_fire) - C_CW'(imem_rsp_valid);
        if (req_fire) begin
            pc_d      = pc_q + 32'd4;
            rq_tail_d = ptr_inc(rq_tail_q);
        end
        // Dropped responses still retire their request-PC entry
        if (imem_rsp_valid) begin
            rq_head_d = ptr_inc(rq_head_q);
        end
        if (redirect) begin
            pc_d    = redirect_target & C_PC_MASK;
            drop_d  = out_d;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - C_CW'(1);
            end
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (buf_pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + C_CW'(push) - C_CW'(buf_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC & C_PC_MASK;
            out_q     <= '0;
            drop_q    <= '0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rq_head_q <= '0;
            rq_tail_q <= '0;
        end else begin
            pc_q      <= pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rq_head_q <= rq_head_d;
            rq_tail_q <= rq_tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            rq_pc_mem[rq_tail_q] <= pc_q;
        end
        if (push) begin
            buf_data_mem[tail_q] <= imem_rsp_data;
            buf_pc_mem[tail_q]   <= rsp_pc;
        end
    end
endmodule
`default_nettype wire
